// File: rtl/fp_array_adder_pkg.sv
// Shared types and float32 constants for the array-sum accelerator.
//   state_t   : job sequencing states of the top FSM
//   EXP_W/MAN_W/BIAS : float32 field layout
//   QNAN / POS_INF / NEG_INF : canonical special results
//   lzc27     : leading-zero count of a 27-bit aligned significand
package fp_array_adder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_ADD   = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  // Returns 27 for an all-zero input; otherwise distance of the top set bit from bit 26.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_add32.sv
// Combinational float32 adder: align, add/subtract, normalise, round-to-nearest-even.
// Subnormal operands/results flush to signed zero; NaN or inf-inf gives QNAN;
// exact cancellation gives +0; overflow gives signed infinity.
// Ports:
//   a, b   : float32 operands
//   sum_c  : float32 sum (combinational)
module fp_add32
  import fp_array_adder_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum_c
);

  localparam int unsigned SIG_W   = MAN_W + 1;  // significand with hidden bit
  localparam int unsigned ALN_W   = SIG_W + 3;  // plus guard, round, sticky
  localparam int          EXP_MAX = int'(2 * BIAS + 1);

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_zero = (ea == '0);  // zero or subnormal, both treated as zero
  assign b_zero = (eb == '0);

  logic             sx;
  logic [EXP_W-1:0] ex, ey, d;
  logic [MAN_W-1:0] fx, fy;
  logic [4:0]       dd, lz;
  logic [2*ALN_W-1:0] shl;
  logic [ALN_W-1:0] mx_al, my_al, norm;
  logic [ALN_W:0]   raw;
  logic             eff_sub, round_up;
  logic [SIG_W-1:0] rnd;
  int               exp_n, exp_r;

  // Finite-operand datapath followed by special-case override.
  always_comb begin
    sum_c    = '0;
    sx       = sa;
    ex       = ea;
    ey       = eb;
    fx       = fa;
    fy       = fb;
    eff_sub  = sa ^ sb;
    norm     = '0;
    lz       = '0;
    exp_n    = 0;

    // Larger magnitude becomes x so the result sign is sx and d is non-negative.
    if ({eb, fb} > {ea, fa}) begin
      sx = sb;
      ex = eb;
      ey = ea;
      fx = fb;
      fy = fa;
    end

    d     = ex - ey;
    dd    = (d > EXP_W'(ALN_W)) ? 5'(ALN_W + 1) : d[4:0];
    mx_al = {1'b1, fx, 3'b000};
    shl   = {{1'b1, fy, 3'b000}, ALN_W'(0)} >> dd;
    my_al = shl[2*ALN_W-1:ALN_W] | {{(ALN_W-1){1'b0}}, |shl[ALN_W-1:0]};

    raw = eff_sub ? ({1'b0, mx_al} - {1'b0, my_al})
                  : ({1'b0, mx_al} + {1'b0, my_al});

    if (raw[ALN_W]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      norm  = {raw[ALN_W:2], raw[1] | raw[0]};
      exp_n = int'(ex) + 1;
    end else begin
      lz    = lzc27(raw[ALN_W-1:0]);
      norm  = raw[ALN_W-1:0] << lz;
      exp_n = int'(ex) - int'(lz);
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[ALN_W-2:3]} + SIG_W'(round_up);
    exp_r    = exp_n + int'(rnd[SIG_W-1]);  // mantissa overflow bumps exponent

    if (raw == '0) begin
      sum_c = 32'h0000_0000;
    end else if (exp_r >= EXP_MAX) begin
      sum_c = sx ? NEG_INF : POS_INF;
    end else if (exp_r <= 0 || !norm[ALN_W-1]) begin
      sum_c = {sx, 31'd0};
    end else begin
      sum_c = {sx, EXP_W'(exp_r), rnd[MAN_W-1:0]};
    end

    if (a_nan || b_nan) begin
      sum_c = QNAN;
    end else if (a_inf && b_inf) begin
      sum_c = (sa != sb) ? QNAN : a;
    end else if (a_inf) begin
      sum_c = a;
    end else if (b_inf) begin
      sum_c = b;
    end else if (a_zero && b_zero) begin
      sum_c = {sa & sb, 31'd0};
    end else if (a_zero) begin
      sum_c = b;
    end else if (b_zero) begin
      sum_c = a;
    end
  end

endmodule

// File: rtl/fp_array_adder.sv
// AXI-Stream float32 array summer: buffers up to SIZE operands from the slave
// stream, sums them one add per cycle after a start pulse, and returns the sum
// as a single TLAST beat on the master stream.
// Optional build macro: FP_ARRAY_ADDER_AUTOSTART_EN -- summation begins as soon
// as loading completes; the start input is then ignored.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, synchronous active-low reset
//   s00_axis_*                     : operand input stream (tready/tdata/tlast/tvalid)
//   m00_axis_*                     : result output stream (tvalid/tdata/tstrb/tlast/tready)
//   start                          : one-cycle pulse to begin summation
module fp_array_adder
  import fp_array_adder_pkg::*;
#(
  parameter int unsigned SIZE       = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  output logic                      s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                      s00_axis_tlast,
  input  logic                      s00_axis_tvalid,
  output logic                      m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(DATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  input  logic                      start
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("fp_array_adder supports DATA_WIDTH=32 only");
  end

  localparam int unsigned CNT_W = $clog2(SIZE + 1);
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  add_idx_q;
  logic [31:0]       acc_q;
  logic [31:0]       mem_q [SIZE];
  logic              s_tready_q, m_tvalid_q, m_tlast_q;
  logic [31:0]       m_tdata_q;
  logic [31:0]       sum_c;
  logic              beat_c, load_done_c, add_done_c, m_hs_c;

  assign beat_c      = s_tready_q & s00_axis_tvalid;
  assign load_done_c = beat_c & (s00_axis_tlast | (count_q == CNT_W'(SIZE - 1)));
  assign add_done_c  = (add_idx_q == IDX_W'(SIZE - 1));
  assign m_hs_c      = m_tvalid_q & m00_axis_tready;

  fp_add32 u_add (
    .a     (acc_q),
    .b     (mem_q[add_idx_q]),
    .sum_c (sum_c)
  );

  // Job sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (load_done_c) begin
`ifdef FP_ARRAY_ADDER_AUTOSTART_EN
          state_d = ST_ADD;
`else
          state_d = ST_READY;
`endif
        end
      end
      ST_READY: if (start)      state_d = ST_ADD;
      ST_ADD:   if (add_done_c) state_d = ST_SEND;
      ST_SEND:  if (m_hs_c)     state_d = ST_LOAD;
      default:                  state_d = ST_LOAD;
    endcase
  end

  // State, buffer, accumulator and registered stream outputs.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q    <= ST_LOAD;
      count_q    <= '0;
      add_idx_q  <= '0;
      acc_q      <= '0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      for (int i = 0; i < int'(SIZE); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      // Handshake flags track the state being entered so they align with it.
      s_tready_q <= (state_d == ST_LOAD);
      m_tvalid_q <= (state_d == ST_SEND);
      m_tlast_q  <= (state_d == ST_SEND);

      if (beat_c) begin
        mem_q[IDX_W'(count_q)] <= s00_axis_tdata;
        count_q                <= count_q + CNT_W'(1);
      end

      if (state_q != ST_ADD && state_d == ST_ADD) begin
        acc_q     <= '0;
        add_idx_q <= '0;
      end else if (state_q == ST_ADD) begin
        acc_q     <= sum_c;
        add_idx_q <= add_idx_q + IDX_W'(1);
        if (add_done_c) m_tdata_q <= sum_c;
      end

      if (state_q == ST_SEND && m_hs_c) begin
        count_q <= '0;
        for (int i = 0; i < int'(SIZE); i++) mem_q[i] <= '0;
      end
    end
  end

  assign s00_axis_tready = s_tready_q;
  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tdata  = m_tdata_q;
  assign m00_axis_tlast  = m_tlast_q;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fp_array_adder.sv
// Scoreboard bench for fp_array_adder: directed float32 jobs with hand-computed sums.
module tb_fp_array_adder;

  localparam int SIZE = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tready, s_tlast, s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        start;

  always #5 clk = ~clk;

  fp_array_adder #(.SIZE(SIZE), .DATA_WIDTH(32)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tvalid (s_tvalid),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .start           (start)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] job[$];
  logic [31:0] one_to_ten[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted result beat is matched against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", m_tdata, 32'hxxxx_xxxx);
      end else begin
        check("result", m_tdata, exp_q.pop_front());
        check("result_tlast", 32'(m_tlast), 32'd1);
        check("result_tstrb", 32'(m_tstrb), 32'hF);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("beat_accept_timeout", 32'(s_tready), 32'd1);
  endtask

  task automatic end_beats();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic send_job(input logic use_last);
    for (int i = 0; i < job.size(); i++)
      send_beat(job[i], use_last && (i == job.size() - 1));
    end_beats();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    start    = 1'b0;
    one_to_ten = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                   32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

    repeat (3) @(negedge clk);
    check("reset_s_tready", 32'(s_tready), 32'd1);
    check("reset_m_tvalid", 32'(m_tvalid), 32'd0);
    check("reset_m_tdata", m_tdata, 32'd0);
    check("reset_m_tlast", 32'(m_tlast), 32'd0);
    rst_n = 1'b1;

    // 1..10 with tlast on the tenth; measure start-to-valid latency.
    job = one_to_ten;
    send_job(1'b1);
    check("full_job_backpressure", 32'(s_tready), 32'd0);
    exp_q.push_back(32'h425C0000);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (m_tvalid) break;
    end
    check("start_latency", 32'(lat), 32'(SIZE + 1));
    wait_drain();

    // Same job with the result stalled for five cycles.
    m_tready = 1'b0;
    job = one_to_ten;
    send_job(1'b1);
    exp_q.push_back(32'h425C0000);
    pulse_start();
    lat = 0;
    while (!m_tvalid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tvalid", 32'(m_tvalid), 32'd1);
      check("stall_tdata", m_tdata, 32'h425C0000);
    end
    m_tready = 1'b1;
    wait_drain();

    // Short job ended by tlast; further beats are back-pressured.
    job = '{32'h3F800000, 32'h40000000, 32'h40400000};
    send_job(1'b1);
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = 32'h41300000;
    @(negedge clk);
    check("short_job_backpressure", 32'(s_tready), 32'd0);
    s_tvalid = 1'b0;
    exp_q.push_back(32'h40C00000);
    pulse_start();
    wait_drain();

    // Exact cancellation, ten beats filled by count (no tlast).
    job = '{32'h3FC00000, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0};
    send_job(1'b0);
    check("count_full_backpressure", 32'(s_tready), 32'd0);
    exp_q.push_back(32'h00000000);
    pulse_start();
    wait_drain();

    // inf + -inf gives the canonical quiet NaN.
    job = '{32'h7F800000, 32'hFF800000};
    send_job(1'b1);
    exp_q.push_back(32'h7FC00000);
    pulse_start();
    wait_drain();

    // Overflow of two max-normal values.
    job = '{32'h7F7FFFFF, 32'h7F7FFFFF};
    send_job(1'b1);
    exp_q.push_back(32'h7F800000);
    pulse_start();
    wait_drain();

    // Tie rounds to even, subnormal operand flushed.
    job = '{32'h3F800000, 32'h33800000, 32'h00000001};
    send_job(1'b1);
    exp_q.push_back(32'h3F800000);
    pulse_start();
    wait_drain();

    // Mixed-sign subtraction with normalisation: 3 - 1 - 0.5.
    job = '{32'h40400000, 32'hBF800000, 32'hBF000000};
    send_job(1'b1);
    exp_q.push_back(32'h3FC00000);
    pulse_start();
    wait_drain();

    // Reset during ADD discards the job and clears outputs.
    job = one_to_ten;
    send_job(1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_m_tdata", m_tdata, 32'd0);
    check("midrst_m_tlast", 32'(m_tlast), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd1);
    rst_n = 1'b1;
    job = one_to_ten;
    send_job(1'b0);
    exp_q.push_back(32'h425C0000);
    pulse_start();
    wait_drain();

    // start while still loading is ignored.
    job = '{32'h3F000000, 32'h3E800000};
    send_job(1'b0);
    pulse_start();
    job = '{32'h3E000000};
    send_job(1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    check("early_start_ignored", 32'(seen), 32'd0);
    exp_q.push_back(32'h3F600000);
    pulse_start();
    wait_drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
